// File: rtl/imem_loader_if.sv
// Host byte stream and instruction-memory write port seen by imem_loader.
// The master modport is the loader side; slave is the host/memory side.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_ready;

    modport master (
        input  in_valid, in_data, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output in_valid, in_data, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Byte-stream program loader: parses A5/LEN/payload/XOR frames, writes 32-bit
// words into instruction memory and releases the CPU only after a verified image.
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    imem_loader_if.master       bus,
    output logic                cpu_rst,
    output logic                done,
    output logic                error,
    output logic [15:0]         words_loaded
);

    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR
    } state_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           wdata;
    } mem_req_t;

    localparam logic [7:0]  SYNC = 8'hA5;
    localparam logic [63:0] CAP  = 64'd1 << ADDR_WIDTH;

    state_t   state, state_d;
    mem_req_t req;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [7:0]  csum;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;
    logic        accept, wr_done, last_word, is_sync;
    logic [15:0] len_n;
    logic        cpu_rst_d, done_d, error_d;

    assign accept    = bus.in_valid && bus.in_ready;
    assign wr_done   = req.we && bus.mem_ready;
    assign last_word = (words_loaded + 16'd1) == len;
    assign is_sync   = bus.in_data == SYNC;
    assign len_n     = {bus.in_data, len_lo};

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE, DONE, ERROR: if (accept && is_sync) state_d = LEN_LO;
            LEN_LO:            if (accept) state_d = LEN_HI;
            LEN_HI: begin
                if (accept) begin
                    if (64'(len_n) > CAP)   state_d = ERROR;
                    else if (len_n == '0)   state_d = CHECK;
                    else                    state_d = DATA;
                end
            end
            DATA:              if (wr_done && last_word) state_d = CHECK;
            CHECK:             if (accept) state_d = (bus.in_data == csum) ? DONE : ERROR;
            default:           state_d = IDLE;
        endcase
    end

    // Bytes are refused only while a write is pending, so nothing is dropped.
    always_comb begin
        bus.in_ready  = !req.we;
        bus.mem_we    = req.we;
        bus.mem_addr  = req.addr;
        bus.mem_wdata = req.wdata;
        cpu_rst_d     = state_d != DONE;
        done_d        = state_d == DONE;
        error_d       = state_d == ERROR;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cpu_rst <= 1'b1;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            cpu_rst <= cpu_rst_d;
            done    <= done_d;
            error   <= error_d;
        end
    end

    // The word address is the count of completed writes: bytes stall while a
    // write is pending, so the two can never drift apart.
    always_ff @(posedge clk) begin
        if (!rst) begin
            req          <= '0;
            len_lo       <= '0;
            len          <= '0;
            csum         <= '0;
            byte_idx     <= '0;
            word_buf     <= '0;
            words_loaded <= '0;
        end else begin
            if (wr_done) begin
                req.we       <= 1'b0;
                words_loaded <= words_loaded + 16'd1;
            end
            if (accept) begin
                case (state)
                    IDLE, DONE, ERROR: begin
                        if (is_sync) begin
                            csum         <= '0;
                            words_loaded <= '0;
                            byte_idx     <= '0;
                            word_buf     <= '0;
                        end
                    end
                    LEN_LO: len_lo <= bus.in_data;
                    LEN_HI: len    <= len_n;
                    DATA: begin
                        csum     <= csum ^ bus.in_data;
                        byte_idx <= byte_idx + 2'd1;
                        word_buf <= {bus.in_data, word_buf[23:8]};
                        if (byte_idx == 2'd3) begin
                            req.we    <= 1'b1;
                            req.addr  <= ADDR_WIDTH'(words_loaded);
                            req.wdata <= {bus.in_data, word_buf};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame-level reference model, a
// write-logging memory and randomized byte gaps / memory backpressure.
module tb_imem_loader;
    localparam int AW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_rst, done, error;
    logic [15:0] words_loaded;

    imem_loader_if #(.ADDR_WIDTH(AW)) bus();

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .cpu_rst      (cpu_rst),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rdy_mode;          // 0: always ready, 1: random, 2: manual_rdy
    logic manual_rdy;
    logic rnd_rdy;
    bit   gap_en;

    logic [AW-1:0] wr_addr_q[$];
    logic [31:0]   wr_data_q[$];
    int            we_cycles = 0;

    logic [7:0]  frame_q[$];
    logic [31:0] exp_words[$];

    assign bus.mem_ready = (rdy_mode == 2) ? manual_rdy : ((rdy_mode == 0) ? 1'b1 : rnd_rdy);

    initial begin
        rnd_rdy = 1'b1;
        forever begin
            @(negedge clk);
            rnd_rdy = ($urandom_range(0, 2) != 0);
        end
    end

    always @(posedge clk) begin
        if (bus.mem_we) we_cycles <= we_cycles + 1;
        if (rst && bus.mem_we && bus.mem_ready) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_wdata);
        end
    end

    // Reference frame: words -> little-endian bytes, checksum = XOR of payload.
    task automatic make_frame(input bit bad);
        logic [7:0]  cs;
        logic [15:0] n;
        n  = 16'(exp_words.size());
        cs = 8'h00;
        frame_q.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(n[7:0]);
        frame_q.push_back(n[15:8]);
        foreach (exp_words[i]) begin
            for (int k = 0; k < 4; k++) begin
                logic [31:0] w;
                w = exp_words[i] >> (8 * k);
                frame_q.push_back(w[7:0]);
                cs = cs ^ w[7:0];
            end
        end
        frame_q.push_back(bad ? (cs ^ 8'h01) : cs);
    endtask

    // Enters and leaves at a negedge; the byte transfers on the posedge between.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            checks++; errors++;
            $display("FAIL send_byte_timeout: in_ready=%b, required 1", bus.in_ready);
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (gap_en) repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic send_frame();
        foreach (frame_q[i]) send_byte(frame_q[i]);
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst: got %b, required 1", cpu_rst); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b, required 0", bus.mem_we); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b, required 0", error); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready); end
        checks++; if (words_loaded !== 16'd0) begin errors++; $display("FAIL reset_words: got %0d, required 0", words_loaded); end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_good_load();
        int base, we0, nbad;
        rdy_mode = 0; gap_en = 0;
        exp_words = {32'h00500013, 32'h00A00093};
        make_frame(1'b0);
        base = wr_addr_q.size(); we0 = we_cycles;
        foreach (frame_q[i]) begin
            send_byte(frame_q[i]);
            if (i == 6) begin
                checks++;
                if (bus.mem_we !== 1'b1 || bus.mem_addr !== '0 || bus.mem_wdata !== 32'h00500013) begin
                    errors++;
                    $display("FAIL good_first_write: we=%b addr=%0d data=%h, required 1 0 00500013",
                             bus.mem_we, bus.mem_addr, bus.mem_wdata);
                end
            end
        end
        nbad = 0;
        foreach (exp_words[i])
            if (wr_addr_q.size() <= base + i || wr_addr_q[base+i] !== AW'(i) || wr_data_q[base+i] !== exp_words[i]) nbad++;
        checks++; if (nbad != 0 || wr_addr_q.size() - base != 2) begin errors++;
            $display("FAIL good_writes: got %0d writes %0d wrong, required 2 writes 0 wrong", wr_addr_q.size() - base, nbad); end
        checks++; if (we_cycles - we0 != 2) begin errors++; $display("FAIL good_we_cycles: got %0d, required 2", we_cycles - we0); end
        checks++; if (done !== 1'b1 || cpu_rst !== 1'b0 || error !== 1'b0) begin errors++;
            $display("FAIL good_flags: done=%b cpu_rst=%b error=%b, required 1 0 0", done, cpu_rst, error); end
        checks++; if (words_loaded !== 16'd2) begin errors++; $display("FAIL good_words: got %0d, required 2", words_loaded); end
    endtask

    task automatic test_backpressure();
        int base, nbad;
        rdy_mode = 2; manual_rdy = 1'b1; gap_en = 0;
        exp_words = {32'h00500013, 32'h00A00093};
        make_frame(1'b0);
        base = wr_addr_q.size();
        for (int i = 0; i < 7; i++) send_byte(frame_q[i]);
        manual_rdy = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = frame_q[7];
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== '0 || bus.mem_wdata !== 32'h00500013 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall%0d: we=%b addr=%0d data=%h in_ready=%b, required 1 0 00500013 0",
                         c, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.in_ready);
            end
            @(negedge clk);
        end
        checks++; if (wr_addr_q.size() != base) begin errors++;
            $display("FAIL bp_no_early_write: got %0d writes, required 0", wr_addr_q.size() - base); end
        manual_rdy = 1'b1;
        for (int i = 7; i < frame_q.size(); i++) send_byte(frame_q[i]);
        nbad = 0;
        foreach (exp_words[i])
            if (wr_addr_q.size() <= base + i || wr_addr_q[base+i] !== AW'(i) || wr_data_q[base+i] !== exp_words[i]) nbad++;
        checks++; if (nbad != 0 || wr_addr_q.size() - base != 2) begin errors++;
            $display("FAIL bp_writes: got %0d writes %0d wrong, required 2 writes 0 wrong", wr_addr_q.size() - base, nbad); end
        checks++; if (done !== 1'b1 || words_loaded !== 16'd2) begin errors++;
            $display("FAIL bp_done: done=%b words=%0d, required 1 2", done, words_loaded); end
        rdy_mode = 0;
    endtask

    task automatic test_bad_checksum();
        rdy_mode = 0; gap_en = 0;
        exp_words = {32'h00500013, 32'h00A00093};
        make_frame(1'b1);
        send_frame();
        checks++; if (error !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0) begin errors++;
            $display("FAIL bad_cs_flags: error=%b cpu_rst=%b done=%b, required 1 1 0", error, cpu_rst, done); end
        checks++; if (words_loaded !== 16'd2) begin errors++; $display("FAIL bad_cs_words: got %0d, required 2", words_loaded); end
        make_frame(1'b0);
        send_frame();
        checks++; if (done !== 1'b1 || error !== 1'b0 || cpu_rst !== 1'b0) begin errors++;
            $display("FAIL bad_cs_recover: done=%b error=%b cpu_rst=%b, required 1 0 0", done, error, cpu_rst); end
    endtask

    task automatic test_length_bounds();
        int we0, base, nbad;
        rdy_mode = 0; gap_en = 0;
        we0 = we_cycles;
        frame_q = {8'hA5, 8'h01, 8'h01};
        send_frame();
        checks++; if (error !== 1'b1 || done !== 1'b0 || cpu_rst !== 1'b1) begin errors++;
            $display("FAIL oversize_flags: error=%b done=%b cpu_rst=%b, required 1 0 1", error, done, cpu_rst); end
        repeat (4) @(negedge clk);
        checks++; if (we_cycles != we0) begin errors++; $display("FAIL oversize_no_write: got %0d we cycles, required 0", we_cycles - we0); end
        frame_q = {8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame();
        checks++; if (done !== 1'b1 || error !== 1'b0 || words_loaded !== 16'd0) begin errors++;
            $display("FAIL zero_len: done=%b error=%b words=%0d, required 1 0 0", done, error, words_loaded); end
        // Full capacity is the largest legal image.
        exp_words.delete();
        for (int i = 0; i < (1 << AW); i++) exp_words.push_back($urandom());
        make_frame(1'b0);
        base = wr_addr_q.size();
        send_frame();
        nbad = 0;
        foreach (exp_words[i])
            if (wr_addr_q.size() <= base + i || wr_addr_q[base+i] !== AW'(i) || wr_data_q[base+i] !== exp_words[i]) nbad++;
        checks++; if (nbad != 0 || wr_addr_q.size() - base != (1 << AW)) begin errors++;
            $display("FAIL full_writes: got %0d writes %0d wrong, required %0d writes 0 wrong", wr_addr_q.size() - base, nbad, 1 << AW); end
        checks++; if (done !== 1'b1 || words_loaded !== 16'(1 << AW)) begin errors++;
            $display("FAIL full_done: done=%b words=%0d, required 1 %0d", done, words_loaded, 1 << AW); end
    endtask

    task automatic test_noise_midreset();
        int base, nbad;
        rdy_mode = 0; gap_en = 0;
        exp_words = {32'h00500013, 32'h00A00093};
        make_frame(1'b0);
        frame_q.push_front(8'h5A);
        frame_q.push_front(8'hFF);
        frame_q.push_front(8'h00);
        base = wr_addr_q.size();
        send_frame();
        checks++; if (done !== 1'b1 || wr_addr_q.size() - base != 2) begin errors++;
            $display("FAIL noise_load: done=%b writes=%0d, required 1 2", done, wr_addr_q.size() - base); end
        frame_q = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
        send_frame();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.mem_we !== 1'b0 || cpu_rst !== 1'b1 || done !== 1'b0 || error !== 1'b0 || words_loaded !== 16'd0) begin
            errors++;
            $display("FAIL midreset: we=%b cpu_rst=%b done=%b error=%b words=%0d, required 0 1 0 0 0",
                     bus.mem_we, cpu_rst, done, error, words_loaded);
        end
        rst = 1'b1;
        @(negedge clk);
        exp_words = {32'hDEADBEEF, 32'h12345678};
        make_frame(1'b0);
        base = wr_addr_q.size();
        send_frame();
        nbad = 0;
        foreach (exp_words[i])
            if (wr_addr_q.size() <= base + i || wr_addr_q[base+i] !== AW'(i) || wr_data_q[base+i] !== exp_words[i]) nbad++;
        checks++; if (nbad != 0 || wr_addr_q.size() - base != 2 || done !== 1'b1) begin errors++;
            $display("FAIL fresh_after_reset: writes=%0d wrong=%0d done=%b, required 2 0 1", wr_addr_q.size() - base, nbad, done); end
    endtask

    task automatic test_random();
        int base, nbad, n;
        bit bad;
        rdy_mode = 1; gap_en = 1;
        for (int f = 0; f < 25; f++) begin
            n   = $urandom_range(0, 5);
            bad = ($urandom_range(0, 3) == 0);
            exp_words.delete();
            for (int i = 0; i < n; i++) exp_words.push_back($urandom());
            make_frame(bad);
            repeat ($urandom_range(0, 2)) begin
                logic [7:0] nz;
                nz = 8'($urandom_range(0, 255));
                if (nz == 8'hA5) nz = 8'h00;
                frame_q.push_front(nz);
            end
            base = wr_addr_q.size();
            send_frame();
            nbad = 0;
            foreach (exp_words[i])
                if (wr_addr_q.size() <= base + i || wr_addr_q[base+i] !== AW'(i) || wr_data_q[base+i] !== exp_words[i]) nbad++;
            checks++; if (nbad != 0 || wr_addr_q.size() - base != n) begin errors++;
                $display("FAIL rand%0d_writes: got %0d writes %0d wrong, required %0d writes 0 wrong", f, wr_addr_q.size() - base, nbad, n); end
            checks++; if (done !== !bad || error !== bad || cpu_rst !== bad || words_loaded !== 16'(n)) begin errors++;
                $display("FAIL rand%0d_flags: done=%b error=%b cpu_rst=%b words=%0d, required %b %b %b %0d",
                         f, done, error, cpu_rst, words_loaded, !bad, bad, bad, n); end
        end
        rdy_mode = 0; gap_en = 0;
    endtask

    initial begin
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rdy_mode     = 0;
        manual_rdy   = 1'b1;
        gap_en       = 0;
        @(negedge clk);
        test_reset();
        test_good_load();
        test_backpressure();
        test_bad_checksum();
        test_length_bounds();
        test_noise_midreset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
